// File: rtl/uart_cmd_pkg.sv
// Shared types and character constants for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_OP = 2'd0,
        ARGS    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_PLUS   = 8'h2b;

endpackage

// File: rtl/hex_nibble_dec.sv
// ASCII hex digit decoder: '0'-'9', 'a'-'f', 'A'-'F' to a 4-bit value.
module hex_nibble_dec (
    input  logic [7:0] ch,
    output logic [3:0] value,
    output logic       is_hex
);

    always_comb begin
        value  = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            value  = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
            // low nibble of 'a'/'A' is 1, so +9 lands on 10
            value  = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "$<op><hex...>+" commands from a toggle-flagged UART byte stream with echo.
// Define UART_CMD_PARSER_STRICT_HEX_EN to reject non-hex argument bytes (sets err).
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_NIBBLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_rch,
    input  logic        rx_rcv,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [63:0] cmd_data,
    output logic [4:0]  cmd_nibbles,
    output logic        echo_valid,
    input  logic        echo_ready,
    output logic [7:0]  echo_ch,
    output logic        err
);

    localparam int          DATA_BITS = 4 * MAX_NIBBLES;
    localparam logic [63:0] DATA_MASK = {64{1'b1}} >> (64 - DATA_BITS);
    localparam logic [4:0]  NIB_MAX   = 5'(MAX_NIBBLES);

    state_t      state, state_n;
    logic        rcv_q;
    logic        byte_ev;
    logic        valid_n;
    logic [7:0]  op_n;
    logic [63:0] data_n;
    logic [4:0]  nib_n;
    logic        echo_new, err_set, err_clr, overrun;
    logic [3:0]  hex_val, nib_val;
    logic        is_hex;

    hex_nibble_dec u_dec (
        .ch     (rx_rch),
        .value  (hex_val),
        .is_hex (is_hex)
    );

    assign byte_ev = (rx_rcv != rcv_q);
    assign nib_val = is_hex ? hex_val : 4'h0;
    assign overrun = echo_new && echo_valid && !echo_ready;

    always_comb begin
        state_n  = state;
        valid_n  = cmd_valid;
        op_n     = cmd_op;
        data_n   = cmd_data;
        nib_n    = cmd_nibbles;
        echo_new = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        if (state == HOLD) begin
            // command is frozen; any incoming byte is lost
            if (byte_ev) err_set = 1'b1;
            if (cmd_valid && cmd_ready) begin
                valid_n = 1'b0;
                op_n    = 8'h00;
                data_n  = 64'h0;
                nib_n   = 5'd0;
                state_n = WAIT_OP;
            end
        end else if (byte_ev) begin
            if (rx_rch == CH_DOLLAR) begin
                op_n     = 8'h00;
                data_n   = 64'h0;
                nib_n    = 5'd0;
                state_n  = WAIT_OP;
                echo_new = 1'b1;
                err_clr  = 1'b1;
            end else if (rx_rch == CH_PLUS) begin
                valid_n = 1'b1;
                state_n = HOLD;
                if (state == WAIT_OP) op_n = 8'h00;
            end else if (state == WAIT_OP) begin
                op_n     = rx_rch;
                state_n  = ARGS;
                echo_new = 1'b1;
            end else begin
                echo_new = 1'b1;
`ifdef UART_CMD_PARSER_STRICT_HEX_EN
                if (!is_hex) begin
                    err_set = 1'b1;
                end else begin
                    data_n = {cmd_data[59:0], nib_val} & DATA_MASK;
                    nib_n  = (cmd_nibbles < NIB_MAX) ? cmd_nibbles + 5'd1 : cmd_nibbles;
                end
`else
                data_n = {cmd_data[59:0], nib_val} & DATA_MASK;
                nib_n  = (cmd_nibbles < NIB_MAX) ? cmd_nibbles + 5'd1 : cmd_nibbles;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        rcv_q <= rx_rcv;
        if (reset) begin
            state       <= WAIT_OP;
            cmd_valid   <= 1'b0;
            cmd_op      <= 8'h00;
            cmd_data    <= 64'h0;
            cmd_nibbles <= 5'd0;
            echo_valid  <= 1'b0;
            echo_ch     <= 8'h00;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_valid   <= valid_n;
            cmd_op      <= op_n;
            cmd_data    <= data_n;
            cmd_nibbles <= nib_n;
            if (echo_new) begin
                echo_valid <= 1'b1;
                echo_ch    <= rx_rch;
            end else if (echo_valid && echo_ready) begin
                echo_valid <= 1'b0;
            end
            // '$' restarts a session, so its clear wins over a same-cycle overrun
            err <= err_clr ? 1'b0 : (err | err_set | overrun);
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (default MAX_NIBBLES).
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_rch;
    logic        rx_rcv;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [63:0] cmd_data;
    logic [4:0]  cmd_nibbles;
    logic        echo_valid;
    logic        echo_ready;
    logic [7:0]  echo_ch;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [7:0] echo_q[$];

    uart_cmd_parser dut (
        .clk         (clk),
        .reset       (reset),
        .rx_rch      (rx_rch),
        .rx_rcv      (rx_rcv),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_nibbles (cmd_nibbles),
        .echo_valid  (echo_valid),
        .echo_ready  (echo_ready),
        .echo_ch     (echo_ch),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && echo_valid && echo_ready) echo_q.push_back(echo_ch);

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_rch = b;
        rx_rcv = ~rx_rcv;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic handshake();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
        checks++; if (echo_valid !== 1'b0) begin errors++; $display("FAIL reset_echo_valid got %b exp 0", echo_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (cmd_op !== 8'h00) begin errors++; $display("FAIL reset_cmd_op got %h exp 00", cmd_op); end
        checks++; if (cmd_data !== 64'h0) begin errors++; $display("FAIL reset_cmd_data got %h exp 0", cmd_data); end
        checks++; if (cmd_nibbles !== 5'd0) begin errors++; $display("FAIL reset_cmd_nibbles got %0d exp 0", cmd_nibbles); end
        checks++; if (echo_ch !== 8'h00) begin errors++; $display("FAIL reset_echo_ch got %h exp 00", echo_ch); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (echo_valid !== 1'b0) begin errors++; $display("FAIL release_no_event got %b exp 0", echo_valid); end
    endtask

    task automatic test_basic_cmd();
        string exp_s = "$L0123";
        echo_q.delete();
        send_str("$L0123+");
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", cmd_valid); end
        checks++; if (cmd_op !== 8'h4c) begin errors++; $display("FAIL basic_op got %h exp 4c", cmd_op); end
        checks++; if (cmd_data !== 64'h123) begin errors++; $display("FAIL basic_data got %h exp 123", cmd_data); end
        checks++; if (cmd_nibbles !== 5'd4) begin errors++; $display("FAIL basic_nibbles got %0d exp 4", cmd_nibbles); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err); end
        repeat (3) @(negedge clk);
        checks++; if (echo_q.size() != exp_s.len()) begin errors++; $display("FAIL basic_echo_len got %0d exp %0d", echo_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < echo_q.size(); i++) begin
            checks++;
            if (echo_q[i] !== exp_s[i]) begin errors++; $display("FAIL basic_echo[%0d] got %h exp %h", i, echo_q[i], exp_s[i]); end
        end
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== 64'h123) begin errors++; $display("FAIL hold_stable got v=%b d=%h exp v=1 d=123", cmd_valid, cmd_data); end
    endtask

    task automatic test_hold_drop();
        echo_q.delete();
        send("x");
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL hold_drop_err got %b exp 1", err); end
        checks++; if (cmd_op !== 8'h4c || cmd_data !== 64'h123) begin errors++; $display("FAIL hold_drop_stable got op=%h d=%h exp op=4c d=123", cmd_op, cmd_data); end
        handshake();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL hs_valid got %b exp 0", cmd_valid); end
        checks++; if (cmd_data !== 64'h0 || cmd_op !== 8'h00 || cmd_nibbles !== 5'd0) begin errors++; $display("FAIL hs_clear got op=%h d=%h n=%0d exp zeros", cmd_op, cmd_data, cmd_nibbles); end
        checks++; if (echo_q.size() != 0) begin errors++; $display("FAIL hold_drop_echo got %0d bytes exp 0", echo_q.size()); end
        // back in WAIT_OP: next byte becomes the op
        send("A");
        checks++; if (cmd_op !== 8'h41) begin errors++; $display("FAIL wait_op_after_hs got %h exp 41", cmd_op); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_saturate();
        send_str("$D");
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dollar_clears_err got %b exp 0", err); end
        for (int i = 0; i < 18; i++) send("f");
        send("+");
        checks++; if (cmd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sat_data got %h exp ffffffffffffffff", cmd_data); end
        checks++; if (cmd_nibbles !== 5'd16) begin errors++; $display("FAIL sat_nibbles got %0d exp 16", cmd_nibbles); end
        checks++; if (cmd_op !== 8'h44) begin errors++; $display("FAIL sat_op got %h exp 44", cmd_op); end
        handshake();
        send("+");
        checks++; if (cmd_valid !== 1'b1 || cmd_op !== 8'h00) begin errors++; $display("FAIL plus_in_wait_op got v=%b op=%h exp v=1 op=00", cmd_valid, cmd_op); end
        handshake();
    endtask

    task automatic test_echo_overrun();
        echo_ready = 1'b0;
        send("$");
        checks++; if (echo_valid !== 1'b1 || echo_ch !== 8'h24 || err !== 1'b0) begin errors++; $display("FAIL ovr_first got v=%b ch=%h e=%b exp 1 24 0", echo_valid, echo_ch, err); end
        send("S");
        checks++; if (echo_ch !== 8'h53) begin errors++; $display("FAIL ovr_ch got %h exp 53", echo_ch); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err got %b exp 1", err); end
        send("$");
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", err); end
        checks++; if (echo_ch !== 8'h24) begin errors++; $display("FAIL ovr_refill got %h exp 24", echo_ch); end
        echo_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (echo_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", echo_valid); end
        echo_q.delete();
    endtask

    task automatic test_back_to_back();
        string s = "$K12";
        echo_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_rch = s[i];
            rx_rcv = ~rx_rcv;
        end
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err); end
        checks++; if (cmd_op !== 8'h4b || cmd_data !== 64'h12 || cmd_nibbles !== 5'd2) begin errors++; $display("FAIL b2b_cmd got op=%h d=%h n=%0d exp 4b 12 2", cmd_op, cmd_data, cmd_nibbles); end
        checks++; if (echo_q.size() != s.len()) begin errors++; $display("FAIL b2b_echo_len got %0d exp %0d", echo_q.size(), s.len()); end
        for (int i = 0; i < s.len() && i < echo_q.size(); i++) begin
            checks++;
            if (echo_q[i] !== s[i]) begin errors++; $display("FAIL b2b_echo[%0d] got %h exp %h", i, echo_q[i], s[i]); end
        end
    endtask

    task automatic test_hex();
        logic [63:0] exp_d;
        logic [4:0]  exp_n;
        logic        exp_e;
        send_str("$Ha9F+");
        checks++; if (cmd_data !== 64'hA9F || cmd_nibbles !== 5'd3) begin errors++; $display("FAIL hex_case got d=%h n=%0d exp a9f 3", cmd_data, cmd_nibbles); end
        handshake();
`ifdef UART_CMD_PARSER_STRICT_HEX_EN
        exp_d = 64'h12;  exp_n = 5'd2; exp_e = 1'b1;
`else
        exp_d = 64'h102; exp_n = 5'd3; exp_e = 1'b0;
`endif
        send_str("$X1g2+");
        checks++; if (cmd_data !== exp_d) begin errors++; $display("FAIL nonhex_data got %h exp %h", cmd_data, exp_d); end
        checks++; if (cmd_nibbles !== exp_n) begin errors++; $display("FAIL nonhex_nibbles got %0d exp %0d", cmd_nibbles, exp_n); end
        checks++; if (err !== exp_e) begin errors++; $display("FAIL nonhex_err got %b exp %b", err, exp_e); end
        handshake();
    endtask

    task automatic test_reset_mid();
        send_str("$L12");
        @(negedge clk);
        reset = 1'b1;
        rx_rch = "Z";
        rx_rcv = ~rx_rcv;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        echo_q.delete();
        repeat (3) @(negedge clk);
        checks++; if (echo_valid !== 1'b0 || echo_q.size() != 0) begin errors++; $display("FAIL rst_mid_event got v=%b n=%0d exp 0 0", echo_valid, echo_q.size()); end
        checks++; if (cmd_valid !== 1'b0 || cmd_op !== 8'h00 || cmd_data !== 64'h0 || cmd_nibbles !== 5'd0 || err !== 1'b0 || echo_ch !== 8'h00) begin
            errors++; $display("FAIL rst_mid_zero got v=%b op=%h d=%h n=%0d e=%b ch=%h exp zeros", cmd_valid, cmd_op, cmd_data, cmd_nibbles, err, echo_ch);
        end
        send_str("$A5+");
        checks++; if (cmd_op !== 8'h41 || cmd_data !== 64'h5) begin errors++; $display("FAIL rst_mid_resume got op=%h d=%h exp 41 5", cmd_op, cmd_data); end
        handshake();
    endtask

    initial begin
        reset      = 1'b1;
        rx_rch     = 8'h00;
        rx_rcv     = 1'b0;
        cmd_ready  = 1'b0;
        echo_ready = 1'b1;
        test_reset();
        test_basic_cmd();
        test_hold_drop();
        test_saturate();
        test_echo_overrun();
        test_back_to_back();
        test_hex();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
